// File: rtl/vga_scan_ctrl.sv
// rtl/vga_scan_ctrl.sv - VGA scan counters with registered, blanked 4-4-4 colour and sync outputs
module vga_scan_ctrl #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] disp_value_RGB,
    input  logic        in_disp_area,
    output logic [9:0]  scan_x,
    output logic [9:0]  scan_y,
    output logic        hs,
    output logic        vs,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        video_on,
    output logic        frame_tick
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS        = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS        = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;
    logic [11:0]      rgb_q, rgb_d;
    logic             video_on_q, video_on_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             frame_tick_q, frame_tick_d;

    logic pix_en;
    logic h_last;
    logic v_last;
    logic active;

    // With CLK_DIV = 1 the divider is pinned at 0, so pix_en is constantly high.
    assign pix_en = (div_q == DIV_LAST);
    assign h_last = (h_cnt_q == H_LAST);
    assign v_last = (v_cnt_q == V_LAST);
    assign active = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);

    always_comb begin
        div_d        = pix_en ? '0 : div_q + 1'b1;
        h_cnt_d      = h_cnt_q;
        v_cnt_d      = v_cnt_q;
        rgb_d        = rgb_q;
        video_on_d   = video_on_q;
        hs_d         = hs_q;
        vs_d         = vs_q;
        frame_tick_d = pix_en && h_last && v_last;
        if (pix_en) begin
            h_cnt_d = h_last ? '0 : h_cnt_q + 10'd1;
            if (h_last) begin
                v_cnt_d = v_last ? '0 : v_cnt_q + 10'd1;
            end
            // Output stage samples the position being left, so it trails the counters by one pixel.
            rgb_d      = (active && in_disp_area) ? disp_value_RGB : 12'h000;
            video_on_d = active;
            hs_d       = !((h_cnt_q >= H_SYNC_FIRST) && (h_cnt_q <= H_SYNC_LAST));
            vs_d       = !((v_cnt_q >= V_SYNC_FIRST) && (v_cnt_q <= V_SYNC_LAST));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q        <= '0;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            rgb_q        <= '0;
            video_on_q   <= 1'b0;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            rgb_q        <= rgb_d;
            video_on_q   <= video_on_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign scan_x     = h_cnt_q;
    assign scan_y     = v_cnt_q;
    assign hs         = hs_q;
    assign vs         = vs_q;
    assign vga_r      = rgb_q[11:8];
    assign vga_g      = rgb_q[7:4];
    assign vga_b      = rgb_q[3:0];
    assign video_on   = video_on_q;
    assign frame_tick = frame_tick_q;
endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb/tb_vga_scan_ctrl.sv - self-checking bench for vga_scan_ctrl against a pixel-count model
module tb_vga_scan_ctrl;
    localparam int D  = 3;
    localparam int HA = 20;
    localparam int HF = 3;
    localparam int HS = 4;
    localparam int HB = 5;
    localparam int VA = 12;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic        clk;
    logic        rst;
    logic [11:0] disp_value_RGB;
    logic        in_disp_area;
    logic [9:0]  scan_x;
    logic [9:0]  scan_y;
    logic        hs;
    logic        vs;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        video_on;
    logic        frame_tick;

    vga_scan_ctrl #(
        .CLK_DIV (D),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .disp_value_RGB(disp_value_RGB),
        .in_disp_area  (in_disp_area),
        .scan_x        (scan_x),
        .scan_y        (scan_y),
        .hs            (hs),
        .vs            (vs),
        .vga_r         (vga_r),
        .vga_g         (vga_g),
        .vga_b         (vga_b),
        .video_on      (video_on),
        .frame_tick    (frame_tick)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int k        = 0;
    int cyc      = 0;
    bit chk_en   = 0;

    logic [11:0] rgb_tab  [HT][VT];
    logic        area_tab [HT][VT];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Model time: number of non-reset edges since the last reset edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) k <= 0;
        else      k <= k + 1;
    end

    // Upstream stand-in: colour/area looked up from the model's current scan position.
    always @(negedge clk) begin
        int p;
        p = k / D;
        disp_value_RGB = rgb_tab[p % HT][(p / HT) % VT];
        in_disp_area   = area_tab[p % HT][(p / HT) % VT];
    end

    always @(negedge clk) begin
        int p, q, qx, qy;
        logic [9:0]  ex, ey;
        logic [11:0] ergb;
        logic        ehs, evs, evon, eft;
        logic [26:0] act_v, exp_v;
        if (chk_en) begin
            p  = k / D;
            ex = 10'(p % HT);
            ey = 10'((p / HT) % VT);
            if (p == 0) begin
                ehs = 1'b1; evs = 1'b1; ergb = 12'h000; evon = 1'b0;
            end else begin
                q    = p - 1;
                qx   = q % HT;
                qy   = (q / HT) % VT;
                evon = (qx < HA) && (qy < VA);
                ergb = (evon && area_tab[qx][qy]) ? rgb_tab[qx][qy] : 12'h000;
                ehs  = !((qx >= HA + HF) && (qx < HA + HF + HS));
                evs  = !((qy >= VA + VF) && (qy < VA + VF + VS));
            end
            eft   = (k > 0) && (k % D == 0) && (p % (HT * VT) == 0);
            act_v = {scan_x, scan_y, hs, vs, vga_r, vga_g, vga_b, video_on, frame_tick} >> 0;
            exp_v = {ex, ey, ehs, evs, ergb, evon, eft};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL model_cmp k=%0d: got x=%0d y=%0d hs=%b vs=%b rgb=%h von=%b ft=%b, expected x=%0d y=%0d hs=%b vs=%b rgb=%h von=%b ft=%b",
                         k, scan_x, scan_y, hs, vs, {vga_r, vga_g, vga_b}, video_on, frame_tick,
                         ex, ey, ehs, evs, ergb, evon, eft);
            end
        end
    end

    // Interval monitors: frame period, sync positions and widths measured in clk cycles.
    int t_tick, t_x, t_hf, t_y, t_vf;
    logic hs_p, vs_p;
    logic [9:0] x_p, y_p;
    always @(negedge clk) begin
        if (!rst || !chk_en) begin
            t_tick = -1; t_x = -1; t_hf = -1; t_y = -1; t_vf = -1;
            hs_p = 1'b1; vs_p = 1'b1; x_p = 10'd0; y_p = 10'd0;
        end else begin
            if (frame_tick) begin
                check("tick_at_origin", {12'd0, scan_x, scan_y}, 32'd0);
                if (t_tick >= 0) check("frame_period", cyc - t_tick, 1824);
                t_tick = cyc;
            end
            if (scan_x == 10'd23 && x_p != 10'd23) t_x = cyc;
            if (scan_y == 10'd14 && scan_x == 10'd0 && !(y_p == 10'd14 && x_p == 10'd0)) t_y = cyc;
            if (!hs && hs_p) begin
                if (t_x >= 0) check("hs_lag", cyc - t_x, 3);
                t_hf = cyc;
            end
            if (hs && !hs_p && t_hf >= 0) check("hs_width", cyc - t_hf, 12);
            if (!vs && vs_p) begin
                if (t_y >= 0) check("vs_lag", cyc - t_y, 3);
                t_vf = cyc;
            end
            if (vs && !vs_p && t_vf >= 0) check("vs_width", cyc - t_vf, 192);
            hs_p = hs; vs_p = vs; x_p = scan_x; y_p = scan_y;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_scan"}, {12'd0, scan_x, scan_y}, 32'd0);
        check({tag, "_sync"}, {30'd0, hs, vs}, 32'd3);
        check({tag, "_rgb"}, {20'd0, vga_r, vga_g, vga_b}, 32'd0);
        check({tag, "_von_ft"}, {30'd0, video_on, frame_tick}, 32'd0);
    endtask

    task automatic check_restart(input string tag, input logic [11:0] rgb00, input logic area00);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 check({tag, "_x_edge2"}, {22'd0, scan_x}, 32'd0);
        @(posedge clk);
        #1 check({tag, "_x_edge3"}, {22'd0, scan_x}, 32'd1);
        check({tag, "_first_pix_von"}, {31'd0, video_on}, 32'd1);
        check({tag, "_first_pix_rgb"}, {20'd0, vga_r, vga_g, vga_b},
              area00 ? {20'd0, rgb00} : 32'd0);
    endtask

    initial begin
        bit found;
        rst = 1'b0;
        for (int i = 0; i < HT; i++)
            for (int j = 0; j < VT; j++) begin
                rgb_tab[i][j]  = 12'hFFF;
                area_tab[i][j] = 1'b1;
            end
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("por");
        check_restart("por", 12'hFFF, 1'b1);
        repeat (3 * 1824) @(posedge clk);

        found = 0;
        for (int n = 0; n < 2000 && !found; n++) begin
            @(negedge clk);
            if (scan_x == 10'd13 && scan_y == 10'd7) found = 1;
        end
        check("midframe_pos_found", {31'd0, found}, 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1 check_reset_outputs("midrst");
        for (int i = 0; i < HT; i++)
            for (int j = 0; j < VT; j++) begin
                rgb_tab[i][j]  = 12'($urandom);
                area_tab[i][j] = ($urandom_range(0, 3) != 0);
            end
        rgb_tab[0][0]  = 12'hA5C;
        area_tab[0][0] = 1'b1;
        repeat (2) @(posedge clk);
        check_restart("midrst", 12'hA5C, 1'b1);
        repeat (3 * 1824) @(posedge clk);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
